// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Round-robin arbiter between the ALU and load-unit writeback requests,
//   with a register-file write port registered one cycle after acceptance
//   and a busy scoreboard for pending destination registers.
//
//   Ports
//     clk, reset                        clock, synchronous active-high reset
//     alu_valid/ready/rd/val            ALU writeback request
//     mem_valid/ready/rd/val            load-unit writeback request
//     issue_valid/ready/rd              destination marked pending at issue
//     rs1, rs2 -> rs1_busy, rs2_busy    operand hazard lookup
//     rf_write, rf_rd, rf_val           register file write enable/index/data
//     rsN_fwd, rsN_fwd_val              operand forwarding from the write port
//     wb_err                            sticky: writeback to a non-busy register
//
//   Build option: define RF_BYPASS_EN to forward the write port onto the
//   operand lookup (and hide the register's busy bit during its write cycle).
module regfile_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_val,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_val,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_write,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_val,
  output logic            rs1_fwd,
  output logic [XLEN-1:0] rs1_fwd_val,
  output logic            rs2_fwd,
  output logic [XLEN-1:0] rs2_fwd_val,
  output logic            wb_err
);

  // Which requester wins when both are valid.
  typedef enum logic {PRI_ALU, PRI_MEM} pri_e;

  pri_e            pri_q, pri_d;
  logic [31:1]     busy_q, busy_d;
  logic            rf_write_q, rf_write_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_val_q, rf_val_d;
  logic            err_q, err_d;

  logic [31:0]     busy_vec;
  logic [31:0]     busy_nx;
  logic            alu_gnt, mem_gnt, wb_acc, issue_set;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_val;

  // x0 is never busy.
  assign busy_vec = {busy_q, 1'b0};

  always_comb begin
    alu_gnt     = !reset && alu_valid && (!mem_valid || pri_q == PRI_ALU);
    mem_gnt     = !reset && mem_valid && (!alu_valid || pri_q == PRI_MEM);
    wb_acc      = alu_gnt || mem_gnt;
    wb_rd       = alu_gnt ? alu_rd  : mem_rd;
    wb_val      = alu_gnt ? alu_val : mem_val;
    issue_ready = !reset && !busy_vec[issue_rd];
    issue_set   = issue_valid && issue_ready && (issue_rd != '0);
  end

  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;

  always_comb begin
    pri_d      = pri_q;
    rf_write_d = wb_acc && (wb_rd != '0);
    rf_rd_d    = rf_rd_q;
    rf_val_d   = rf_val_q;
    err_d      = err_q;
    busy_nx    = busy_vec;

    if (alu_gnt) pri_d = PRI_MEM;
    else if (mem_gnt) pri_d = PRI_ALU;

    if (rf_write_d) begin
      rf_rd_d  = wb_rd;
      rf_val_d = wb_val;
    end

    if (wb_acc && (wb_rd != '0) && !busy_vec[wb_rd]) err_d = 1'b1;

    // Issue stalls on a busy register, so clear and set never hit the same bit.
    if (rf_write_q) busy_nx[rf_rd_q] = 1'b0;
    if (issue_set)  busy_nx[issue_rd] = 1'b1;
    busy_d = busy_nx[31:1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pri_q      <= PRI_ALU;
      busy_q     <= '0;
      rf_write_q <= 1'b0;
      rf_rd_q    <= '0;
      rf_val_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      pri_q      <= pri_d;
      busy_q     <= busy_d;
      rf_write_q <= rf_write_d;
      rf_rd_q    <= rf_rd_d;
      rf_val_q   <= rf_val_d;
      err_q      <= err_d;
    end
  end

  assign rf_write = rf_write_q;
  assign rf_rd    = rf_rd_q;
  assign rf_val   = rf_val_q;
  assign wb_err   = err_q;

`ifdef RF_BYPASS_EN
  logic rs1_hit, rs2_hit;
  always_comb begin
    rs1_hit     = rf_write_q && (rf_rd_q == rs1) && (rs1 != '0);
    rs2_hit     = rf_write_q && (rf_rd_q == rs2) && (rs2 != '0);
    rs1_fwd     = rs1_hit;
    rs2_fwd     = rs2_hit;
    rs1_fwd_val = rs1_hit ? rf_val_q : '0;
    rs2_fwd_val = rs2_hit ? rf_val_q : '0;
    rs1_busy    = busy_vec[rs1] && !rs1_hit;
    rs2_busy    = busy_vec[rs2] && !rs2_hit;
  end
`else
  always_comb begin
    rs1_fwd     = 1'b0;
    rs2_fwd     = 1'b0;
    rs1_fwd_val = '0;
    rs2_fwd_val = '0;
    rs1_busy    = busy_vec[rs1];
    rs2_busy    = busy_vec[rs2];
  end
`endif

endmodule
